// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset/NOP constants,
// fetch state encoding and base opcodes used by fetch and decode.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [0:0] REQ   = 1'b0;
  localparam logic [0:0] VALID = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus; master is the fetch stage, slave the memory.
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches and holds one
// instruction for the decoder until it is acknowledged or redirected away.
module fetch_unit #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ack,
  output logic            misaligned
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(3'd4);

  logic [0:0]      state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] pending_pc_r;
  logic            drop_pending_r;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] eff_target_s;
  logic            target_misaligned_s;

  // Align the redirect target; a redirect this cycle outranks a stored one.
  always_comb begin
    target_s            = {redirect_target[XLEN-1:2], 2'b00};
    target_misaligned_s = (redirect_target[1:0] != 2'b00);
    if (redirect) begin
      eff_target_s = target_s;
    end else begin
      eff_target_s = pending_pc_r;
    end
  end

  assign imem.imem_req  = (state_r == REQ) && !reset;
  assign imem.imem_addr = fetch_pc_r;

  // Fetch FSM, PC/pending-redirect registers and the registered decode outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= REQ;
      fetch_pc_r     <= RESET_PC;
      pending_pc_r   <= RESET_PC;
      drop_pending_r <= 1'b0;
      instr          <= NOP_INSTR;
      pc             <= RESET_PC;
      pc_plus4       <= RESET_PC + WORD_STEP;
      instr_valid    <= 1'b0;
      misaligned     <= 1'b0;
    end else begin
      misaligned <= redirect && target_misaligned_s;
      case (state_r)
        REQ: begin
          if (imem.imem_ready) begin
            // A response to a fetch that a redirect invalidated is dropped.
            if (redirect || drop_pending_r) begin
              fetch_pc_r     <= eff_target_s;
              drop_pending_r <= 1'b0;
            end else begin
              instr       <= imem.imem_rdata;
              pc          <= fetch_pc_r;
              pc_plus4    <= fetch_pc_r + WORD_STEP;
              instr_valid <= 1'b1;
              state_r     <= VALID;
            end
          end else if (redirect) begin
            pending_pc_r   <= target_s;
            drop_pending_r <= 1'b1;
          end
        end
        VALID: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_pc_r  <= target_s;
            state_r     <= REQ;
          end else if (instr_ack) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_pc_r  <= pc + WORD_STEP;
            state_r     <= REQ;
          end
        end
        default: begin
          state_r     <= REQ;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed walk through the fetch scenarios,
// then randomized traffic compared every cycle against a queue-based model.
module tb_fetch_unit;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        misaligned;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (imem),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instr_ack       (instr_ack),
    .misaligned      (misaligned)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the held instruction (0 or 1 entries), the stored redirect
  // (0 or 1 entries, latest wins), the address of the outstanding fetch.
  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } held_t;

  held_t       held_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_pc;
  bit          m_mis;

  task automatic model_reset();
    held_q.delete();
    pend_q.delete();
    m_fetch = 32'h0000_0000;
    m_pc    = 32'h0000_0000;
    m_mis   = 1'b0;
  endtask

  task automatic step(input bit rst, input bit rdy, input logic [31:0] rdata,
                      input bit redir, input logic [31:0] tgt, input bit ack);
    logic [63:0] wide;
    logic [31:0] exp_instr;
    logic [31:0] aligned;
    bit          holding;
    @(posedge clk);
    #1;
    holding   = (held_q.size() != 0);
    exp_instr = holding ? held_q[0].word : NOP_INSTR;
    wide      = {32'h0000_0000, m_pc} + 64'd4;
    check_val("instr_valid", {31'd0, instr_valid}, {31'd0, holding});
    check_val("instr", instr, exp_instr);
    check_val("pc", pc, m_pc);
    check_val("pc_plus4", pc_plus4, wide[31:0]);
    check_val("misaligned", {31'd0, misaligned}, {31'd0, m_mis});

    reset            = rst;
    imem.imem_ready  = rdy;
    imem.imem_rdata  = rdata;
    redirect         = redir;
    redirect_target  = tgt;
    instr_ack        = ack;
    #1;
    check_val("imem_req", {31'd0, imem.imem_req}, {31'd0, (!rst && !holding)});
    if (!rst && !holding) begin
      check_val("imem_addr", imem.imem_addr, m_fetch);
    end

    aligned = tgt & 32'hFFFF_FFFC;
    if (rst) begin
      model_reset();
    end else begin
      m_mis = redir && (tgt[1:0] != 2'b00);
      if (!holding) begin
        if (rdy) begin
          if (redir) begin
            m_fetch = aligned;
            pend_q.delete();
          end else if (pend_q.size() != 0) begin
            m_fetch = pend_q.pop_front();
          end else begin
            held_q.push_back('{word: rdata, addr: m_fetch});
            m_pc = m_fetch;
          end
        end else if (redir) begin
          pend_q.delete();
          pend_q.push_back(aligned);
        end
      end else if (redir) begin
        held_q.delete();
        m_fetch = aligned;
      end else if (ack) begin
        wide    = {32'h0000_0000, held_q[0].addr} + 64'd4;
        m_fetch = wide[31:0];
        held_q.delete();
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0040;
      1:       return 32'h0000_0102;
      2:       return 32'hFFFF_FFFC;
      3:       return 32'hFFFF_FFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset           = 1'b1;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0000_0000;
    redirect        = 1'b0;
    redirect_target = 32'h0000_0000;
    instr_ack       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Zero-wait fetch, ack, next sequential address.
    step(1'b0, 1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b0);
    check_val("first_addr", imem.imem_addr, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b1);
    check_val("first_pc4", pc_plus4, 32'h0000_0004);
    step(1'b0, 1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b0);
    check_val("addr_after_ack", imem.imem_addr, 32'h0000_0004);
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 1'b1);

    // Stalled memory at 0x8.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, $urandom, 1'b0, 32'h0, 1'b0);
      check_val("stall_addr", imem.imem_addr, 32'h0000_0008);
      check_val("stall_req", {31'd0, imem.imem_req}, 32'd1);
    end

    // Redirect while stalled: response dropped, refetch at target.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0093, 1'b0, 32'h0, 1'b0);
    check_val("drop_addr", imem.imem_addr, 32'h0000_0100);
    check_val("drop_valid", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b1);
    step(1'b0, 1'b1, 32'h0000_00B3, 1'b0, 32'h0, 1'b0);

    // Redirect and ack together in VALID: redirect wins.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1);
    check_val("held_pc", pc, 32'h0000_0010);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
    check_val("redir_valid", {31'd0, instr_valid}, 32'd0);
    check_val("redir_nop", instr, 32'h0000_0013);
    check_val("redir_addr", imem.imem_addr, 32'h0000_0040);

    // Misaligned target 0x102 -> 0x100, single-cycle flag.
    step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    check_val("mis_pulse", {31'd0, misaligned}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    check_val("mis_clear", {31'd0, misaligned}, 32'd0);
    check_val("mis_addr", imem.imem_addr, 32'h0000_0100);

    // Top-of-memory wrap, then reset mid-fetch.
    step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    check_val("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_val("wrap_pc4", pc_plus4, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_val("wrap_next", imem.imem_addr, 32'h0000_0000);
    step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    check_val("reset_req", {31'd0, imem.imem_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_val("reset_addr", imem.imem_addr, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 6),
           $urandom,
           ($urandom_range(0, 99) < 15),
           pick_target(),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
